// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================
// lcd_pkg : shared pixel-path types, widths and helpers
// Rev 1.0
// ============================================================
package lcd_pkg;

  localparam int PIX_W   = 24;
  localparam int CH_W    = 8;
  localparam int ALPHA_W = 9;
  localparam int NUM_CH  = 3;

  localparam logic [ALPHA_W-1:0] ALPHA_ONE = 9'd256;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  // Channel 0 is blue, 2 is red (R sits in the MSBs of RGB888)
  function automatic logic [CH_W-1:0] ch_slice(input logic [PIX_W-1:0] pix, input int ch);
    return pix[ch*CH_W +: CH_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_alpha_blend.sv
`default_nettype none
// ============================================================
// lcd_alpha_blend : 2-stage RGB888 cross-fade, new*a + old*(256-a)
// Rev 1.0
// ============================================================
module lcd_alpha_blend
  import lcd_pkg::*;
(
  input  logic               lcd_clk_33m,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   new_pix,
  input  logic [PIX_W-1:0]   old_pix,
  input  logic [ALPHA_W-1:0] alpha,
  output logic [PIX_W-1:0]   pix
);

  logic [PIX_W-1:0]   new_q;
  logic [PIX_W-1:0]   old_q;
  logic [ALPHA_W-1:0] alpha_q;
  logic [ALPHA_W-1:0] weight_old;
  logic [PIX_W-1:0]   blend;

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      new_q   <= '0;
      old_q   <= '0;
      alpha_q <= '0;
    end else begin
      new_q   <= new_pix;
      old_q   <= old_pix;
      alpha_q <= alpha;
    end
  end

  assign weight_old = ALPHA_ONE - alpha_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [16:0] prod_new;
    logic [16:0] prod_old;
    logic [16:0] sum;
    logic        unused_bits;

    assign prod_new = {9'd0, ch_slice(new_q, c)} * {8'd0, alpha_q};
    assign prod_old = {9'd0, ch_slice(old_q, c)} * {8'd0, weight_old};
    assign sum      = prod_new + prod_old;
    // Weights sum to 256, so the result never exceeds 255 and bit 16 stays clear
    assign blend[c*CH_W +: CH_W] = sum[15:8];
    assign unused_bits = &{1'b0, sum[16], sum[7:0]};
  end

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      pix <= '0;
    end else begin
      pix <= blend;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_layer_sel.sv
`default_nettype none
// ============================================================
// lcd_layer_sel : frame-synchronous N-source selector with cut/cross-fade
// Rev 1.0
// ============================================================
module lcd_layer_sel
  import lcd_pkg::*;
#(
  parameter  int NUM_SRC     = 4,
  parameter  int FADE_FRAMES = 16,
  localparam int SEL_W       = $clog2(NUM_SRC)
) (
  input  logic                     lcd_clk_33m,
  input  logic                     rst_n,
  input  logic [NUM_SRC*PIX_W-1:0] src_pix,
  input  logic [SEL_W-1:0]         sel_req,
  input  logic                     fade_en,
  input  logic                     frame_start,
  output logic [PIX_W-1:0]         pix_out,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     busy,
  output logic                     sel_err
);

  localparam logic [ALPHA_W-1:0] STEP      = ALPHA_W'(256 / FADE_FRAMES);
  localparam logic [SEL_W:0]     NUM_SRC_V = (SEL_W+1)'(NUM_SRC);

  state_t             state;
  logic [SEL_W-1:0]   prev_sel;
  logic [ALPHA_W-1:0] alpha;
  logic               req_ok;
  logic               fade_step;
  logic               decide;
  logic [PIX_W-1:0]   src_arr [NUM_SRC];

  assign req_ok    = ({1'b0, sel_req} < NUM_SRC_V);
  assign fade_step = frame_start && (state == FADE) && (alpha != ALPHA_ONE);
  // A completed fade evaluates the request on the same boundary as IDLE would
  assign decide    = frame_start && !fade_step;

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      active_sel <= '0;
      prev_sel   <= '0;
      alpha      <= ALPHA_ONE;
      busy       <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      sel_err <= 1'b0;
      if (fade_step) begin
        alpha <= alpha + STEP;
      end else if (decide) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (!req_ok) begin
          sel_err <= 1'b1;
        end else if (sel_req != active_sel) begin
          active_sel <= sel_req;
          if (fade_en) begin
            prev_sel <= active_sel;
            alpha    <= STEP;
            busy     <= 1'b1;
            state    <= FADE;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign src_arr[k] = src_pix[k*PIX_W +: PIX_W];
  end

  lcd_alpha_blend u_blend (
    .lcd_clk_33m (lcd_clk_33m),
    .rst_n       (rst_n),
    .new_pix     (src_arr[active_sel]),
    .old_pix     (src_arr[prev_sel]),
    .alpha       (alpha),
    .pix         (pix_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_lcd_layer_sel.sv
`default_nettype none
// ============================================================
// tb_lcd_layer_sel : scoreboard bench for lcd_layer_sel
// Rev 1.0
// ============================================================
module tb_lcd_layer_sel;

  localparam int NUM_SRC     = 5;
  localparam int FADE_FRAMES = 4;
  localparam int SEL_W       = $clog2(NUM_SRC);
  localparam int STEP        = 256 / FADE_FRAMES;
  localparam int FLEN        = 8;

  logic                   clk   = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_SRC*24-1:0]  src_pix;
  logic [SEL_W-1:0]       sel_req;
  logic                   fade_en;
  logic                   frame_start;
  logic [23:0]            pix_out;
  logic [SEL_W-1:0]       active_sel;
  logic                   busy;
  logic                   sel_err;

  logic [23:0] src [NUM_SRC];

  always #15 clk = ~clk;

  always_comb begin
    src_pix = '0;
    for (int k = 0; k < NUM_SRC; k++) src_pix[k*24 +: 24] = src[k];
  end

  lcd_layer_sel #(
    .NUM_SRC     (NUM_SRC),
    .FADE_FRAMES (FADE_FRAMES)
  ) dut (
    .lcd_clk_33m (clk),
    .rst_n       (rst_n),
    .src_pix     (src_pix),
    .sel_req     (sel_req),
    .fade_en     (fade_en),
    .frame_start (frame_start),
    .pix_out     (pix_out),
    .active_sel  (active_sel),
    .busy        (busy),
    .sel_err     (sel_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] blend_ref(input logic [23:0] nw, input logic [23:0] od, input int a);
    logic [23:0] r;
    int n, o;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      n = int'(nw[c*8 +: 8]);
      o = int'(od[c*8 +: 8]);
      r[c*8 +: 8] = 8'((n * a + o * (256 - a)) / 256);
    end
    return r;
  endfunction

  // Behavioural model of the selection state; expected pixels are queued per sampled cycle
  int          m_act, m_prev, m_alpha;
  bit          m_busy, m_err;
  logic [23:0] exp_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_prev = 0; m_alpha = 256; m_busy = 0; m_err = 0;
      exp_q.delete();
    end else begin
      exp_q.push_back((m_alpha == 256) ? src[m_act] : blend_ref(src[m_act], src[m_prev], m_alpha));
      m_err = 0;
      if (frame_start) begin
        if (m_busy && m_alpha < 256) begin
          m_alpha += STEP;
        end else begin
          m_busy = 0;
          if (int'(sel_req) >= NUM_SRC) begin
            m_err = 1;
          end else if (int'(sel_req) != m_act) begin
            if (fade_en) begin
              m_prev = m_act; m_alpha = STEP; m_busy = 1;
            end
            m_act = int'(sel_req);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_pix_out", pix_out, 0);
      check("rst_active_sel", active_sel, 0);
      check("rst_busy", busy, 0);
      check("rst_sel_err", sel_err, 0);
    end else begin
      if (exp_q.size() >= 2) check("sb_pix", pix_out, exp_q.pop_front());
      check("sb_active_sel", active_sel, m_act);
      check("sb_busy", busy, m_busy);
      check("sb_sel_err", sel_err, m_err);
    end
  end

  task automatic frame(input int sel, input bit fade, input int len);
    frame_start = 1'b1;
    sel_req     = SEL_W'(sel);
    fade_en     = fade;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (len - 1) @(negedge clk);
  endtask

  task automatic marker(input int k);
    logic [23:0] base;
    base   = src[k];
    src[k] = 24'h123456;
    @(negedge clk);
    src[k] = base;
    check("lat_before", pix_out, base);
    @(negedge clk);
    check("lat_marker", pix_out, 24'h123456);
    @(negedge clk);
    check("lat_after", pix_out, base);
  endtask

  initial begin
    src[0] = 24'hFF0000; src[1] = 24'h00FF00; src[2] = 24'h0000FF;
    src[3] = 24'hFFFFFF; src[4] = 24'h808080;
    sel_req = '0; fade_en = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pix", pix_out, 0);
    check("reset_sel", active_sel, 0);
    rst_n = 1'b1;
    frame(0, 0, FLEN);
    check("idle_src0", pix_out, 24'hFF0000);

    frame(2, 0, FLEN);
    check("cut_pix", pix_out, 24'h0000FF);
    check("cut_sel", active_sel, 2);
    check("cut_busy", busy, 0);
    marker(2);
    frame(0, 0, FLEN);
    check("cut_back", pix_out, 24'hFF0000);

    frame(2, 1, FLEN);
    check("fade_a64", pix_out, 24'hBF003F);
    check("fade_busy", busy, 1);
    frame(2, 1, FLEN);
    check("fade_a128", pix_out, 24'h7F007F);
    frame(2, 1, FLEN);
    check("fade_a192", pix_out, 24'h3F00BF);
    frame(2, 1, FLEN);
    check("fade_a256", pix_out, 24'h0000FF);
    check("fade_busy_hold", busy, 1);
    marker(2);
    frame(2, 0, FLEN);
    check("fade_done", busy, 0);

    frame(1, 1, FLEN);
    for (int i = 0; i < 3; i++) begin
      frame(3, 1, FLEN);
      check("midfade_ignored", active_sel, 1);
    end
    frame(3, 0, FLEN);
    check("midfade_accept", active_sel, 3);
    check("midfade_pix", pix_out, 24'hFFFFFF);

    frame_start = 1'b1; sel_req = SEL_W'(6); fade_en = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    check("err_pulse", sel_err, 1);
    @(negedge clk);
    check("err_clear", sel_err, 0);
    repeat (5) @(negedge clk);
    check("err_sel_kept", active_sel, 3);
    check("err_pix_kept", pix_out, 24'hFFFFFF);

    for (int i = 0; i < 6; i++) frame(0, 1, 1);
    frame(0, 0, FLEN);
    check("b2b_pix", pix_out, 24'hFF0000);

    frame(4, 1, FLEN);
    frame(4, 1, 3);
    check("fade_mid_a128", pix_out, 24'hBF4040);
    #5 rst_n = 1'b0;
    #1;
    check("rst_now_pix", pix_out, 0);
    check("rst_now_sel", active_sel, 0);
    check("rst_now_busy", busy, 0);
    sel_req = '0; fade_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("refill_0", pix_out, 0);
    @(negedge clk);
    check("refill_src0", pix_out, 24'hFF0000);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lcd_layer_sel.md
# lcd_layer_sel

Frame-synchronous N-source pixel selector for the LCD pixel path, generalising the single-bit UI/image display-mode mux. It sits between the pixel generators (numeric-pad UI, image, future overlays) and the LCD controller's data input. Source changes take effect only at frame boundaries, so the screen never tears. The new source either cuts in immediately or cross-fades in over a configurable number of frames.

## Interface
- NUM_SRC, 4: number of pixel sources, 2..8
- FADE_FRAMES, 16: frames per cross-fade; power of two, 1..256
- SEL_W, $clog2(NUM_SRC): select width (derived, not overridden)
- lcd_clk_33m  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- src_pix  in  NUM_SRC*24  source pixels; source k in bits [24k+23:24k], RGB888 with R in the MSBs
- sel_req  in  SEL_W  requested source, level, sampled only at frame_start
- fade_en  in  1  0 = cut, 1 = cross-fade; sampled at request acceptance
- frame_start  in  1  one-cycle pulse, at least one cycle before the first active pixel of a frame
- pix_out  out  24  selected/blended pixel to the LCD controller
- active_sel  out  SEL_W  current (destination) source
- busy  out  1  fade in progress
- sel_err  out  1  one-cycle pulse when an out-of-range request is rejected

## Operation
- State: IDLE, FADE. Registers: active_sel, prev_sel, alpha (9 bit, 0..256), busy. STEP = 256/FADE_FRAMES.
- IDLE, frame_start, sel_req ≥ NUM_SRC: request ignored; sel_err = 1 for that cycle; no state change.
- IDLE, frame_start, sel_req == active_sel: no action.
- IDLE, frame_start, valid sel_req ≠ active_sel, fade_en = 0: active_sel ← sel_req; alpha stays at 256; remain in IDLE.
- IDLE, frame_start, valid new request, fade_en = 1: prev_sel ← active_sel; active_sel ← sel_req; alpha ← STEP; busy ← 1; go to FADE.
- FADE, frame_start, alpha < 256: alpha ← alpha + STEP. sel_req and fade_en are ignored.
- FADE, frame_start, alpha == 256: busy ← 0 and return to IDLE. In the same cycle, evaluate sel_req exactly as in IDLE, so a pending request can start the next cut or fade immediately.
- FADE_FRAMES = 1: alpha reaches 256 on the accepting frame_start. The switch still occupies one frame as FADE, with output equal to the new source.
- Blend, per 8-bit channel: out = (new·alpha + old·(256−alpha)) >> 8, with 17-bit intermediates and truncation. alpha = 256 gives exactly the new source; prev_sel is not used then.
- Only the latest sel_req at a frame_start matters. Intermediate requests are not queued.
- Reset values: active_sel 0, prev_sel 0, alpha 256, busy 0, sel_err 0, pix_out 0, pipeline registers 0.
- Reset asserted mid-fade: everything returns to reset values, and the output is source 0 once the pipeline refills.

## Timing
- Pixel latency: fixed 2 cycles in every mode. src_pix sampled at cycle t appears on pix_out at t+2. The upstream sync/DE path must be delayed by 2 cycles to match.
- Stage 1 registers the two muxed pixels (new, old) and alpha. Stage 2 registers the blend result.
- Selection and alpha registers update on the frame_start edge. They apply to src_pix sampled from cycle t+1 onward, where frame_start is at t.
- active_sel, busy and sel_err are registered. They change the cycle after the frame_start that causes the change.
- frame_start pulses on consecutive cycles: each pulse is a full frame boundary. No special-casing.

## Structure
- Shared package lcd_pkg: PIX_W = 24, CH_W = 8, ALPHA_W = 9, an RGB channel-slice helper, and the state enum {IDLE, FADE}.
- Sub-module lcd_alpha_blend: 2-stage pipelined three-channel blend (new, old, alpha → pix). It is reusable for future overlay layers.
- Top-level: request/FSM logic plus the NUM_SRC:1 muxes for the new and old pixel.

## Test plan
- Cut: sources 0..3 = 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF; sel_req = 2, fade_en = 0, frame_start → pix_out = 0x0000FF from input cycle t+1 (seen at t+3); active_sel = 2; busy stays 0.
- Fade, FADE_FRAMES = 4, old 0xFF0000 → new 0x0000FF: successive frames give pix_out 0xBF003F, 0x7F007F, 0x3F00BF, 0x0000FF. busy falls after the 4th following frame_start.
- Request mid-fade: sel_req changes 1 → 3 during a fade → ignored until completion; accepted on the frame_start that clears busy.
- Out of range: NUM_SRC = 3, sel_req = 3 at frame_start → one-cycle sel_err; active_sel and pix_out unchanged.
- Reset mid-fade at alpha = 128 → all outputs 0 immediately; after release, source 0 pixels appear at 2-cycle latency.
- Latency: a single-cycle marker pixel 0x123456 on the active source appears on pix_out exactly 2 cycles later, in both cut and fade modes.
